// File: rtl/jam_cost_rom.sv
// jam_cost_rom: NxN worker/job cost table for the job-assignment engine.
// The table is filled through a streaming load port, and each (W,J) lookup is answered one cycle later.
module jam_cost_rom #(
    parameter int N    = 8,
    parameter int IDXW = 3,
    parameter int CW   = 7
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            LD_START,
    input  logic            LD_VALID,
    input  logic [CW-1:0]   LD_DATA,
    output logic            LD_READY,
    output logic            LD_DONE,
    input  logic [IDXW-1:0] W,
    input  logic [IDXW-1:0] J,
    output logic [CW-1:0]   Cost,
    output logic [15:0]     RD_CNT
);

    localparam int PTR_W = 2 * IDXW;
    localparam int DEPTH = N * N;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SERVE
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ld_ptr;
    logic [CW-1:0]    mem [DEPTH];
    logic             accept;
    logic [PTR_W-1:0] rd_addr;

    // A start pulse always wins over a word presented in the same cycle.
    assign accept  = (state == LOAD) && LD_VALID && LD_READY && !LD_START;
    assign rd_addr = {W, J};

    // Table storage is deliberately left out of reset so a RAM can be inferred.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[ld_ptr] <= LD_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            ld_ptr   <= '0;
            LD_READY <= 1'b0;
            LD_DONE  <= 1'b0;
            Cost     <= '0;
            RD_CNT   <= '0;
        end else if (LD_START) begin
            state    <= LOAD;
            ld_ptr   <= '0;
            LD_READY <= 1'b1;
            LD_DONE  <= 1'b0;
            Cost     <= '0;
            RD_CNT   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    Cost <= '0;
                    if (accept) begin
                        if (ld_ptr == LAST_PTR) begin
                            state    <= SERVE;
                            ld_ptr   <= '0;
                            LD_READY <= 1'b0;
                            LD_DONE  <= 1'b1;
                        end else begin
                            ld_ptr <= ld_ptr + 1'b1;
                        end
                    end
                end
                SERVE: begin
                    Cost <= mem[rd_addr];
                    if (RD_CNT != 16'hFFFF) begin
                        RD_CNT <= RD_CNT + 16'd1;
                    end
                end
                default: begin
                    Cost <= '0;
                end
            endcase
        end
    end

endmodule
